// File: rtl/matrix_loader_if.sv
// Byte-stream handshake between the host-side bus and the matrix loader.
// The source holds in_data and in_valid until a rising edge sees in_ready high.
interface matrix_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/matrix_loader.sv
// Assembles two zero-padded 5x5 signed 8-bit operand matrices (A, then B) from a
// valid/ready byte stream and holds them stable for the combinational multiplier.

// One 5-byte matrix row; cleared on a new load, written one element per transfer.
module matrix_loader_row (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [2:0]  col,
  input  logic [7:0]  wdata,
  output logic [39:0] row_data
);
  logic [4:0][7:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (clr)     row_d      = '0;
    else if (we) row_d[col] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
  end

  assign row_data = row_q;
endmodule

module matrix_loader (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           size,
  matrix_loader_if.slave       bus,
  output logic [199:0]         matrix_a,
  output logic [199:0]         matrix_b,
  output logic                 mats_valid,
  output logic                 done,
  output logic                 busy,
  output logic                 size_err
);
  localparam int DIM = 5;
  localparam int EW  = 8;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_e;

  state_e     state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       done_q, done_d;
  logic       mats_valid_q, mats_valid_d;
  logic       size_err_q, size_err_d;

  logic       loading, xfer, last_col, last_elem, size_ok;
  logic       clr, we_a, we_b;

  // Ready depends only on registered state so the source never sees a comb path.
  assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer      = loading && bus.in_valid;
  assign last_col  = (col_q == n_q - 3'd1);
  assign last_elem = last_col && (row_q == n_q - 3'd1);
  assign size_ok   = (size >= 3'd2) && (size <= 3'd5);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    row_d        = row_q;
    col_d        = col_q;
    done_d       = 1'b0;
    mats_valid_d = mats_valid_q;
    size_err_d   = size_err_q;
    clr          = 1'b0;
    we_a         = 1'b0;
    we_b         = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mats_valid_d = 1'b0;
          if (size_ok) begin
            n_d        = size;
            row_d      = '0;
            col_d      = '0;
            size_err_d = 1'b0;
            clr        = 1'b1;
            state_d    = LOAD_A;
          end else begin
            // Bad size keeps the previous matrices but no longer vouches for them.
            size_err_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          we_a = (state_q == LOAD_A);
          we_b = (state_q == LOAD_B);
          if (last_elem) begin
            row_d = '0;
            col_d = '0;
            if (state_q == LOAD_A) begin
              state_d = LOAD_B;
            end else begin
              state_d      = DONE;
              mats_valid_d = 1'b1;
              done_d       = 1'b1;
            end
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      done_q       <= 1'b0;
      mats_valid_q <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      row_q        <= row_d;
      col_q        <= col_d;
      done_q       <= done_d;
      mats_valid_q <= mats_valid_d;
      size_err_q   <= size_err_d;
    end
  end

  // Rows at index >= n are never selected, which leaves the zero padding in place.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    matrix_loader_row u_row_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .we       (we_a && (row_q == 3'(r))),
      .col      (col_q),
      .wdata    (bus.in_data),
      .row_data (matrix_a[r*DIM*EW +: DIM*EW])
    );
    matrix_loader_row u_row_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .we       (we_b && (row_q == 3'(r))),
      .col      (col_q),
      .wdata    (bus.in_data),
      .row_data (matrix_b[r*DIM*EW +: DIM*EW])
    );
  end

  assign bus.in_ready = loading;
  assign busy         = loading;
  assign done         = done_q;
  assign mats_valid   = mats_valid_q;
  assign size_err     = size_err_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: vector table, hand sequences for reset and
// illegal sizes, and random loads checked against a packed-matrix reference model.
module tb_matrix_loader;
  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [2:0]   size;
  logic [199:0] matrix_a, matrix_b;
  logic         mats_valid, done, busy, size_err;
  int           checks = 0, failures = 0;
  logic [199:0] last_a = '0, last_b = '0;

  matrix_loader_if bus();

  matrix_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .bus(bus),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .mats_valid(mats_valid),
    .done(done), .busy(busy), .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_SEQ, K_FIX2, K_RAND} kind_e;
  typedef struct {
    int    n;
    int    mode;      // 0 continuous, 1 alternate stall, 2 random stall
    kind_e kind;
    int    inj;       // byte index at which a (to-be-ignored) start is pulsed, -1 none
    bit    tail;      // check the cycle after done; 0 means next load starts in DONE
    int    exp_done;  // cycles from start edge to done, -1 = derive from stalls
  } vec_t;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference placement: element k of a row-major n x n list lands at (k/n, k%n) of 5x5.
  function automatic logic [199:0] pack(input int n, input logic [7:0] v[25]);
    logic [199:0] r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        r[(i*5+j)*8 +: 8] = v[i*n+j];
    return r;
  endfunction

  function automatic logic [199:0] prod(input logic [199:0] a, input logic [199:0] b);
    logic [199:0] r = '0;
    int s;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        s = 0;
        for (int k = 0; k < 5; k++)
          s += int'($signed(a[(i*5+k)*8 +: 8])) * int'($signed(b[(k*5+j)*8 +: 8]));
        r[(i*5+j)*8 +: 8] = 8'(s);
      end
    return r;
  endfunction

  task automatic do_load(input int n, input logic [7:0] av[25], input logic [7:0] bv[25],
                         input int mode, input int inj, input bit tail, input int exp_done,
                         input logic [199:0] exp_prod, input bit chk_prod);
    int nb, cyc, stalls, done_at, want;
    bit st;
    logic [199:0] ea, eb;
    nb = n*n; ea = pack(n, av); eb = pack(n, bv);
    start = 1'b1; size = 3'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_flags {busy,rdy,mv,err}", 200'({busy, bus.in_ready, mats_valid, size_err}), 200'(4'b1100));
    chk("start_clear_a", matrix_a, '0);
    chk("start_clear_b", matrix_b, '0);
    cyc = 0; stalls = 0; done_at = 0;
    for (int k = 0; k < 2*nb; k++) begin
      st = (mode == 1 && (k % 2) == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
      if (st) begin
        bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
        @(posedge clk); #1;
        cyc++; stalls++;
        if (done && done_at == 0) done_at = cyc + 1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (k < nb) ? av[k] : bv[k-nb];
      if (k == inj) begin start = 1'b1; size = 3'd2; end
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      if (done && done_at == 0) done_at = cyc + 1;
    end
    bus.in_valid = 1'b0;
    want = (exp_done < 0) ? 2*nb + 1 + stalls : exp_done;
    chk("done_cycle", 200'(done_at), 200'(want));
    chk("end_flags {done,mv,busy,rdy}", 200'({done, mats_valid, busy, bus.in_ready}), 200'(4'b1100));
    chk("matrix_a", matrix_a, ea);
    chk("matrix_b", matrix_b, eb);
    if (chk_prod) chk("product", prod(matrix_a, matrix_b), exp_prod);
    last_a = ea; last_b = eb;
    if (tail) begin
      @(posedge clk); #1;
      chk("after_done {done,mv,busy}", 200'({done, mats_valid, busy}), 200'(3'b010));
      chk("hold_a", matrix_a, ea);
      chk("hold_b", matrix_b, eb);
    end
  endtask

  initial begin
    vec_t         tbl[6];
    logic [7:0]   av[25], bv[25], pv[25];
    logic [199:0] ep;
    logic [2:0]   ill[4];
    int           n;

    rst_n = 1'b0; start = 1'b0; size = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", matrix_a, '0);
    chk("reset_b", matrix_b, '0);
    chk("reset_flags", 200'({mats_valid, done, busy, bus.in_ready, size_err}), '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of loading A.
    start = 1'b1; size = 3'd5;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_data = 8'(k + 1);
      @(posedge clk); #1;
    end
    chk("midload_a_first", 200'(matrix_a[7:0]), 200'(8'd1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", matrix_a, '0);
    chk("async_rst_flags", 200'({mats_valid, done, busy, bus.in_ready, size_err}), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst {busy,rdy}", 200'({busy, bus.in_ready}), '0);
    bus.in_valid = 1'b0;

    tbl[0] = '{5, 0, K_SEQ,  -1, 1'b1, 51};
    tbl[1] = '{2, 0, K_FIX2, -1, 1'b1, 9};
    tbl[2] = '{3, 1, K_RAND, -1, 1'b1, 28};
    tbl[3] = '{4, 0, K_RAND, 19, 1'b0, 33};
    tbl[4] = '{2, 0, K_RAND, -1, 1'b1, 9};
    tbl[5] = '{5, 1, K_RAND, -1, 1'b1, 76};
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 25; k++) begin
        av[k] = 8'($urandom); bv[k] = 8'($urandom); pv[k] = '0;
      end
      ep = '0;
      if (tbl[t].kind == K_SEQ) begin
        for (int k = 0; k < 25; k++) begin
          av[k] = 8'(k + 1);
          bv[k] = (k / 5 == k % 5) ? 8'd1 : 8'd0;
        end
        ep = pack(5, av);
      end else if (tbl[t].kind == K_FIX2) begin
        av[0] = 8'd1; av[1] = 8'd2; av[2] = 8'd3; av[3] = 8'd4;
        bv[0] = 8'd5; bv[1] = 8'd6; bv[2] = 8'd7; bv[3] = 8'd8;
        pv[0] = 8'd19; pv[1] = 8'd22; pv[2] = 8'd43; pv[3] = 8'd50;
        ep = pack(2, pv);
      end
      do_load(tbl[t].n, av, bv, tbl[t].mode, tbl[t].inj, tbl[t].tail,
              tbl[t].exp_done, ep, tbl[t].kind != K_RAND);
      if (t == 0) begin
        chk("seq_a_first", 200'(last_a[7:0]), 200'(8'd1));
        chk("seq_a_last", 200'(matrix_a[199:192]), 200'(8'd25));
      end
    end

    // Illegal sizes: flag set, stay idle, matrices kept, mats_valid dropped.
    ill[0] = 3'd6; ill[1] = 3'd0; ill[2] = 3'd1; ill[3] = 3'd7;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; size = ill[i];
      @(posedge clk); #1;
      start = 1'b0;
      chk("bad_size_err", 200'(size_err), 200'(1'b1));
      chk("bad_size_flags {busy,rdy,mv,done}", 200'({busy, bus.in_ready, mats_valid, done}), '0);
      chk("bad_size_keep_a", matrix_a, last_a);
      chk("bad_size_keep_b", matrix_b, last_b);
    end
    for (int k = 0; k < 25; k++) begin av[k] = 8'($urandom); bv[k] = 8'($urandom); end
    do_load(3, av, bv, 0, -1, 1'b1, 19, '0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(2, 5);
      for (int k = 0; k < 25; k++) begin av[k] = 8'($urandom); bv[k] = 8'($urandom); end
      do_load(n, av, bv, 2, -1, 1'($urandom_range(0, 1)), -1, '0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the combinational 5x5 signed 8-bit matrix multiplier in the coprocessor. It accepts a byte stream from the host-side bus under a valid/ready handshake and assembles the two 200-bit operand vectors, matrix A then matrix B, zero-padded to 5x5 for sizes 2..5. It then holds them stable with a valid flag so the multiplier output can be sampled.

## Interface
- Parameters: none; the geometry is fixed at 5x5 x 8 bit to match the multiplier.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a new load; sampled only in IDLE or DONE.
- size  in  3  matrix dimension n, sampled with start; legal values 2..5.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  element byte, two's complement, row-major, A first then B.
- in_ready  out  1  loader accepts a byte this cycle.
- matrix_a  out  200  element (i,j) at bits [(i*5+j)*8 +: 8].
- matrix_b  out  200  same packing as matrix_a.
- mats_valid  out  1  both matrices complete and stable.
- done  out  1  one-cycle pulse when the final B byte has been taken.
- busy  out  1  high in LOAD_A or LOAD_B.
- size_err  out  1  sticky flag: a start arrived with an illegal size.

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE or DONE with start=1:
  - size in 2..5: latch n; clear matrix_a, matrix_b, row and col to 0; clear mats_valid and size_err; go to LOAD_A.
  - Illegal size (0, 1, 6, 7): set size_err; stay in or return to IDLE; clear mats_valid; leave the matrices unchanged.
- start in LOAD_A or LOAD_B is ignored. No abort input exists; only rst_n aborts a load.
- in_ready = 1 exactly when the state is LOAD_A or LOAD_B. It is decoded from the registered state only, never from in_valid.
- Transfer = in_valid && in_ready at a rising edge. The byte is written to element (row,col) of the current matrix. Then col increments; at col = n-1, col wraps to 0 and row increments.
- Elements with row >= n or col >= n are never written and stay 0. This gives zero padding, so the multiplier's 5x5 result equals the n x n product in its top-left corner and is 0 elsewhere.
- Transfer at row = col = n-1 in LOAD_A: reset row and col to 0, go to LOAD_B.
- Transfer at row = col = n-1 in LOAD_B: go to DONE; set mats_valid; pulse done.
- DONE holds matrix_a, matrix_b and mats_valid until the next legal start.
- in_valid with in_ready = 0 is ignored, and no data is lost from the loader's side. The source must hold the byte until it is accepted.
- Bytes are stored verbatim; the loader performs no arithmetic and no range checks.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; row, col and n cleared; matrix_a = 0, matrix_b = 0, mats_valid = 0, done = 0, busy = 0, in_ready = 0, size_err = 0.
- A reset in the middle of a load discards everything; outputs take their reset values immediately.
- Start accepted at edge E: busy and in_ready are high in the cycle after E.
- The first byte can be accepted at edge E+1.
- With in_valid held high, the last B byte is accepted at edge E+2n^2.
- done is high for the single cycle after that edge. mats_valid rises in the same cycle, and busy and in_ready fall in the same cycle.
- Total latency from start to mats_valid is 2n^2+1 cycles, for example 51 cycles at n = 5.
- Stalls (in_valid low) add one cycle each and leave all counters unchanged.
- done never asserts for two consecutive cycles.
- start at the same edge as done's cycle (state DONE) is legal and starts a new load immediately. mats_valid falls at that edge.

## Test plan
- Reset mid-load: drive start with size=5, then 10 bytes, then assert rst_n low → all outputs 0 asynchronously, state IDLE, in_ready = 0.
- Full 5x5 load, continuous valid:
  - Stimulus: A bytes 1..25, then B = identity (1 on the diagonal, 0 elsewhere).
  - Required: done exactly 51 cycles after start; matrix_a[7:0] = 1; matrix_a[199:192] = 25; multiplier result_out equals matrix_a; overflow_flag = 0.
- 2x2 load with padding:
  - Stimulus: A = {1,2,3,4}, B = {5,6,7,8}.
  - Required: matrix_a bytes 0, 1, 5, 6 = 1, 2, 3, 4; every other byte 0; result top-left = 19, 22, 43, 50; all other result bytes 0.
- Back-pressure: toggle in_valid 1,0,1,0 during a 3x3 load → exactly 18 transfers; matrices correct; done delayed by one cycle for each stall cycle.
- Illegal size: start with size=6 → size_err = 1, state stays IDLE, in_ready = 0. A following start with size=3 clears size_err and begins LOAD_A.
- Start ignored while busy, back-to-back reload:
  - Stimulus: pulse start with size=2 during LOAD_B of a size=4 load.
  - Required: the size=4 load completes correctly.
  - Then start with size=2 in the DONE cycle → mats_valid falls, the matrices are zeroed, and the new load proceeds.
